// File: rtl/bandit_pkg.sv
// Shared state codes and symbol-match helper for the one-armed-bandit controller.
package bandit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARMED  = 4'd1,
    ST_SPIN   = 4'd2,
    ST_STOP   = 4'd3,
    ST_EVAL   = 4'd4,
    ST_PAYOUT = 4'd5
  } state_t;

  // Codes 6..15 fall back here.
  localparam state_t ST_DEFAULT = ST_IDLE;

  // Symbol buses are widened to this size before matching (8 reels of up to 8 bits).
  localparam int SYM_BUS_W = 64;

  function automatic logic all_equal(input logic [SYM_BUS_W-1:0] bus, input int n, input int w);
    logic [SYM_BUS_W-1:0] mask;
    logic [SYM_BUS_W-1:0] first;
    logic                 eq;
    mask  = (SYM_BUS_W'(1) << w) - SYM_BUS_W'(1);
    first = bus & mask;
    eq    = 1'b1;
    for (int i = 1; i < 8; i++) begin
      if (i < n && ((bus >> (i * w)) & mask) != first) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/bandit_timer.sv
// Clearable up-counter with terminal-count compare, shared by spin and stagger intervals.
// Latency: tc is combinational from the count; backpressure: none, clr wins over en.
module bandit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/bandit_ctrl.sv
// Bandit game controller: credits, staggered reel stop, win evaluation and payout.
// Latency: all outputs registered, one edge after the causing pulse; backpressure: none, pulses outside their state are dropped.
module bandit_ctrl
  import bandit_pkg::*;
#(
  parameter int NUM_REELS      = 3,
  parameter int SYM_W          = 3,
  parameter int CREDIT_W       = 4,
  parameter int SPIN_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int WIN_CREDITS    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coin_p,
  input  logic                       start_p,
  input  logic                       stop_p,
  input  logic [NUM_REELS*SYM_W-1:0] sym,
  output logic [3:0]                 cur_state,
  output logic [CREDIT_W-1:0]        credits,
  output logic [NUM_REELS-1:0]       reel_spin,
  output logic                       win_p
);

  localparam int T_MAX   = (SPIN_CYCLES > STAGGER_CYCLES) ? SPIN_CYCLES : STAGGER_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_REELS + 1);
  localparam int SUM_W   = CREDIT_W + 4;

  localparam logic [SUM_W-1:0]   CRED_MAX  = SUM_W'((1 << CREDIT_W) - 1);
  localparam logic [TIMER_W-1:0] SPIN_TERM = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STAG_TERM = TIMER_W'(STAGGER_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credits_d;
  logic [NUM_REELS-1:0] reel_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 win_d;
  logic                 start_acc;
  logic                 timer_clr, timer_en, timer_tc;
  logic [TIMER_W-1:0]   timer_term;
  logic [SUM_W-1:0]     sum;

  bandit_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .term  (timer_term),
    .tc    (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    reel_d     = reel_spin;
    idx_d      = idx_q;
    start_acc  = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    timer_term = SPIN_TERM;
    case (state_q)
      ST_IDLE: begin
        if (credits != '0) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (start_p && credits != '0) begin
          start_acc = 1'b1;
          state_d   = ST_SPIN;
          reel_d    = '1;
          idx_d     = '0;
          timer_clr = 1'b1;
        end else if (credits == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SPIN: begin
        timer_en = 1'b1;
        if (timer_tc || stop_p) begin
          state_d   = ST_STOP;
          timer_clr = 1'b1;
        end
      end
      ST_STOP: begin
        timer_en   = 1'b1;
        timer_term = STAG_TERM;
        // One idle STOP cycle after the last reel halts, then evaluate.
        if (idx_q == IDX_W'(NUM_REELS)) begin
          state_d   = ST_EVAL;
          timer_clr = 1'b1;
        end else if (timer_tc) begin
          for (int i = 0; i < NUM_REELS; i++) begin
            if (idx_q == IDX_W'(i)) reel_d[i] = 1'b0;
          end
          idx_d     = idx_q + IDX_W'(1);
          timer_clr = 1'b1;
        end
      end
      ST_EVAL: begin
        if (all_equal(SYM_BUS_W'(sym), NUM_REELS, SYM_W)) state_d = ST_PAYOUT;
        else if (credits != '0)                            state_d = ST_ARMED;
        else                                               state_d = ST_IDLE;
      end
      ST_PAYOUT: begin
        state_d = ST_ARMED;
      end
      default: begin
        state_d   = ST_DEFAULT;
        reel_d    = '0;
        idx_d     = '0;
        timer_clr = 1'b1;
      end
    endcase
    win_d = (state_d == ST_PAYOUT);
  end

  // Widened sum so coin + payout cannot wrap before saturation.
  always_comb begin
    sum = SUM_W'(credits) + SUM_W'(coin_p)
        + ((state_q == ST_PAYOUT) ? SUM_W'(WIN_CREDITS) : '0)
        - SUM_W'(start_acc);
    credits_d = (sum > CRED_MAX) ? CRED_MAX[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      credits   <= '0;
      reel_spin <= '0;
      idx_q     <= '0;
      win_p     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits   <= credits_d;
      reel_spin <= reel_d;
      idx_q     <= idx_d;
      win_p     <= win_d;
    end
  end

  assign cur_state = state_q;

endmodule
